// File: rtl/ifu_pkg.sv
// Shared types and sizes for the instruction-fetch refill path.
package ifu_pkg;

  localparam int TAG_WIDTH      = 28;
  localparam int LINE_WIDTH     = 128;
  localparam int WORD_WIDTH     = 32;
  localparam int MEM_ADDR_WIDTH = 30;
  localparam int WORDS_PER_LINE = LINE_WIDTH / WORD_WIDTH;
  localparam int BEAT_WIDTH     = $clog2(WORDS_PER_LINE);

  localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_RESP  = 2'd3
  } rsp_state_t;

  // Word address of one beat of a line; the beat index fills the low bits,
  // so walking the beats never carries into a neighbouring line.
  function automatic logic [MEM_ADDR_WIDTH-1:0] beat_addr(
    input logic [TAG_WIDTH-1:0]  tag,
    input logic [BEAT_WIDTH-1:0] beat
  );
    logic [TAG_WIDTH+BEAT_WIDTH-1:0] full;
    full = {tag, beat};
    return MEM_ADDR_WIDTH'(full);
  endfunction

endpackage

// File: rtl/ifu_mem_rsp.sv
// Line-refill responder: reads a cache line one word per cycle from a
// synchronous instruction RAM and returns it with its tag as a one-cycle pulse.
module ifu_mem_rsp
  import ifu_pkg::*;
(
  input  logic                      Clock,
  input  logic                      Rst,
  input  logic [TAG_WIDTH-1:0]      cache_reqTagIn,
  input  logic                      cache_reqTagValidIn,
  output logic [TAG_WIDTH-1:0]      cache_rspTagOut,
  output logic [LINE_WIDTH-1:0]     cache_rspInsLineOut,
  output logic                      cache_rspInsLineValidOut,
  output logic                      imem_rdEnOut,
  output logic [MEM_ADDR_WIDTH-1:0] imem_rdAddrOut,
  input  logic [WORD_WIDTH-1:0]     imem_rdDataIn,
  output logic                      busyOut,
  output logic [1:0]                debug_state,
  output logic [15:0]               debug_fetchCount,
  output logic [15:0]               debug_dropCount
);

  rsp_state_t                state_q, state_d;
  logic [TAG_WIDTH-1:0]      tag_q, tag_d;
  logic [BEAT_WIDTH-1:0]     beat_q, beat_d;
  logic                      stale_q, stale_d;
  logic                      rd_en;
  logic                      req_mismatch;

  // Read-enable and beat delayed by one cycle to line up with RAM data.
  logic                      rden_dly_q;
  logic [BEAT_WIDTH-1:0]     beat_dly_q;
  logic [LINE_WIDTH-1:0]     line_q;
  logic [LINE_WIDTH-1:0]     line_cap;

  logic [TAG_WIDTH-1:0]      rsp_tag_q;
  logic [LINE_WIDTH-1:0]     rsp_line_q;
  logic                      rsp_vld_q;
  logic [15:0]               fetch_cnt_q;
  logic [15:0]               drop_cnt_q;

  // Next-state, read issue and stale tracking.
  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    beat_d       = beat_q;
    stale_d      = stale_q;
    rd_en        = 1'b0;
    req_mismatch = !cache_reqTagValidIn || (cache_reqTagIn != tag_q);
    unique case (state_q)
      S_IDLE: begin
        if (cache_reqTagValidIn) begin
          tag_d   = cache_reqTagIn;
          stale_d = 1'b0;
          beat_d  = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        rd_en  = 1'b1;
        beat_d = beat_q + BEAT_WIDTH'(1);
        if (req_mismatch) stale_d = 1'b1;
        if (beat_q == LAST_BEAT) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (req_mismatch) stale_d = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Merge the word returning this cycle into the line buffer image.
  always_comb begin
    line_cap = line_q;
    if (rden_dly_q) begin
      for (int k = 0; k < WORDS_PER_LINE; k++) begin
        if (beat_dly_q == BEAT_WIDTH'(k)) line_cap[k*WORD_WIDTH +: WORD_WIDTH] = imem_rdDataIn;
      end
    end
  end

  // FSM, request latch and read-data capture registers.
  always_ff @(posedge Clock) begin
    if (Rst) begin
      state_q    <= S_IDLE;
      tag_q      <= '0;
      beat_q     <= '0;
      stale_q    <= 1'b0;
      rden_dly_q <= 1'b0;
      beat_dly_q <= '0;
      line_q     <= '0;
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      beat_q     <= beat_d;
      stale_q    <= stale_d;
      rden_dly_q <= rd_en;
      beat_dly_q <= beat_q;
      if (state_q == S_FETCH || state_q == S_DRAIN) line_q <= line_cap;
    end
  end

  // Response registers load as the last word lands so they are valid in S_RESP;
  // a stale line leaves them holding the previous response.
  always_ff @(posedge Clock) begin
    if (Rst) begin
      rsp_vld_q   <= 1'b0;
      rsp_tag_q   <= '0;
      rsp_line_q  <= '0;
      fetch_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      rsp_vld_q <= (state_q == S_DRAIN) && !stale_d;
      if (state_q == S_DRAIN && !stale_d) begin
        rsp_tag_q  <= tag_q;
        rsp_line_q <= line_cap;
      end
      if (state_q == S_RESP) begin
        if (stale_q) drop_cnt_q  <= drop_cnt_q + 16'd1;
        else         fetch_cnt_q <= fetch_cnt_q + 16'd1;
      end
    end
  end

  assign imem_rdEnOut             = rd_en;
  assign imem_rdAddrOut           = rd_en ? beat_addr(tag_q, beat_q) : '0;
  assign cache_rspInsLineValidOut = rsp_vld_q;
  assign cache_rspTagOut          = rsp_tag_q;
  assign cache_rspInsLineOut      = rsp_line_q;
  assign busyOut                  = (state_q != S_IDLE);
  assign debug_state              = state_q;
  assign debug_fetchCount         = fetch_cnt_q;
  assign debug_dropCount          = drop_cnt_q;

endmodule

// File: tb/tb_ifu_mem_rsp.sv
// Directed bench for ifu_mem_rsp with a queue-based scoreboard for read
// addresses and line responses, each tagged with its expected cycle.
module tb_ifu_mem_rsp;

  logic         Clock = 1'b0;
  logic         Rst;
  logic [27:0]  cache_reqTagIn;
  logic         cache_reqTagValidIn;
  logic [27:0]  cache_rspTagOut;
  logic [127:0] cache_rspInsLineOut;
  logic         cache_rspInsLineValidOut;
  logic         imem_rdEnOut;
  logic [29:0]  imem_rdAddrOut;
  logic [31:0]  imem_rdDataIn = 32'hDEADBEEF;
  logic         busyOut;
  logic [1:0]   debug_state;
  logic [15:0]  debug_fetchCount;
  logic [15:0]  debug_dropCount;

  ifu_mem_rsp dut (
    .Clock                    (Clock),
    .Rst                      (Rst),
    .cache_reqTagIn           (cache_reqTagIn),
    .cache_reqTagValidIn      (cache_reqTagValidIn),
    .cache_rspTagOut          (cache_rspTagOut),
    .cache_rspInsLineOut      (cache_rspInsLineOut),
    .cache_rspInsLineValidOut (cache_rspInsLineValidOut),
    .imem_rdEnOut             (imem_rdEnOut),
    .imem_rdAddrOut           (imem_rdAddrOut),
    .imem_rdDataIn            (imem_rdDataIn),
    .busyOut                  (busyOut),
    .debug_state              (debug_state),
    .debug_fetchCount         (debug_fetchCount),
    .debug_dropCount          (debug_dropCount)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [29:0] addr;
    int          cyc;
  } rd_exp_t;

  typedef struct {
    logic [27:0]  tag;
    logic [127:0] line;
    int           cyc;
  } rsp_exp_t;

  rd_exp_t  rd_q[$];
  rsp_exp_t rsp_q[$];
  int       cyc = 0;
  int       n_cmp = 0;
  int       n_bad = 0;
  int       t0;

  always @(posedge Clock) cyc <= cyc + 1;

  // RAM model: word at address A holds A; poison when not read.
  always @(posedge Clock) begin
    if (imem_rdEnOut === 1'b1) imem_rdDataIn <= {2'b00, imem_rdAddrOut};
    else                       imem_rdDataIn <= 32'hDEADBEEF;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic push_rd(input logic [29:0] base, input int first_cyc, input int n);
    for (int k = 0; k < n; k++) begin
      rd_exp_t e;
      e.addr = base + 30'(k);
      e.cyc  = first_cyc + k;
      rd_q.push_back(e);
    end
  endtask

  task automatic push_rsp(input logic [27:0] tag, input logic [127:0] line, input int c);
    rsp_exp_t e;
    e.tag  = tag;
    e.line = line;
    e.cyc  = c;
    rsp_q.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_rsp_vld"},  128'(cache_rspInsLineValidOut), 128'd0);
    chk({pfx, "_rd_en"},    128'(imem_rdEnOut),             128'd0);
    chk({pfx, "_rd_addr"},  128'(imem_rdAddrOut),           128'd0);
    chk({pfx, "_rsp_tag"},  128'(cache_rspTagOut),          128'd0);
    chk({pfx, "_rsp_line"}, cache_rspInsLineOut,            128'd0);
    chk({pfx, "_fetch"},    128'(debug_fetchCount),         128'd0);
    chk({pfx, "_drop"},     128'(debug_dropCount),          128'd0);
    chk({pfx, "_busy"},     128'(busyOut),                  128'd0);
    chk({pfx, "_state"},    128'(debug_state),              128'd0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT reads or responds.
  always @(negedge Clock) begin
    if (imem_rdEnOut === 1'b1) begin
      if (rd_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rd_unexpected at cycle %0d: got read of %h, expected none", cyc, imem_rdAddrOut);
      end else begin
        rd_exp_t e;
        e = rd_q.pop_front();
        chk("rd_addr", 128'(imem_rdAddrOut), 128'(e.addr));
        chk("rd_cycle", 128'(cyc), 128'(e.cyc));
      end
    end
    if (cache_rspInsLineValidOut === 1'b1) begin
      if (rsp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rsp_unexpected at cycle %0d: got tag %h, expected no response", cyc, cache_rspTagOut);
      end else begin
        rsp_exp_t e;
        e = rsp_q.pop_front();
        chk("rsp_tag", 128'(cache_rspTagOut), 128'(e.tag));
        chk("rsp_line", cache_rspInsLineOut, e.line);
        chk("rsp_cycle", 128'(cyc), 128'(e.cyc));
      end
    end
  end

  initial begin
    Rst = 1'b1;
    cache_reqTagValidIn = 1'b0;
    cache_reqTagIn = '0;
    wait_cycles(3);
    Rst = 1'b0;
    @(negedge Clock);
    chk_all_zero("reset");

    // Single miss
    wait_cycles(1);
    t0 = cyc;
    cache_reqTagIn = 28'h0000005;
    cache_reqTagValidIn = 1'b1;
    push_rd(30'h14, t0 + 1, 4);
    push_rsp(28'h0000005, 128'h00000017_00000016_00000015_00000014, t0 + 6);
    wait_cycles(7);
    cache_reqTagValidIn = 1'b0;
    @(negedge Clock);
    chk("miss_fetch", 128'(debug_fetchCount), 128'd1);
    chk("miss_state", 128'(debug_state), 128'd0);

    // Stale fetch: valid dropped two cycles in
    wait_cycles(1);
    t0 = cyc;
    cache_reqTagValidIn = 1'b1;
    push_rd(30'h14, t0 + 1, 4);
    wait_cycles(2);
    cache_reqTagValidIn = 1'b0;
    wait_cycles(5);
    @(negedge Clock);
    chk("stale_drop", 128'(debug_dropCount), 128'd1);
    chk("stale_fetch", 128'(debug_fetchCount), 128'd1);
    chk("stale_state", 128'(debug_state), 128'd0);
    chk("stale_hold_tag", 128'(cache_rspTagOut), 128'h5);

    // Tag change mid-fetch
    wait_cycles(1);
    t0 = cyc;
    cache_reqTagIn = 28'h0000005;
    cache_reqTagValidIn = 1'b1;
    push_rd(30'h14, t0 + 1, 4);
    wait_cycles(2);
    cache_reqTagIn = 28'h0000009;
    push_rd(30'h24, t0 + 8, 4);
    push_rsp(28'h0000009, 128'h00000027_00000026_00000025_00000024, t0 + 13);
    wait_cycles(12);
    cache_reqTagValidIn = 1'b0;
    @(negedge Clock);
    chk("chg_drop", 128'(debug_dropCount), 128'd2);
    chk("chg_fetch", 128'(debug_fetchCount), 128'd2);
    chk("chg_hold_tag", 128'(cache_rspTagOut), 128'h9);

    // Address edge: top of the address space
    wait_cycles(1);
    t0 = cyc;
    cache_reqTagIn = 28'hFFFFFFF;
    cache_reqTagValidIn = 1'b1;
    push_rd(30'h3FFFFFFC, t0 + 1, 4);
    push_rsp(28'hFFFFFFF, 128'h3FFFFFFF_3FFFFFFE_3FFFFFFD_3FFFFFFC, t0 + 6);
    wait_cycles(7);
    cache_reqTagValidIn = 1'b0;
    @(negedge Clock);
    chk("edge_fetch", 128'(debug_fetchCount), 128'd3);

    // Reset in the middle of a fetch
    wait_cycles(1);
    t0 = cyc;
    cache_reqTagIn = 28'h0000005;
    cache_reqTagValidIn = 1'b1;
    push_rd(30'h14, t0 + 1, 3);
    wait_cycles(3);
    Rst = 1'b1;
    cache_reqTagValidIn = 1'b0;
    wait_cycles(1);
    Rst = 1'b0;
    @(negedge Clock);
    chk_all_zero("midrst");
    wait_cycles(1);
    t0 = cyc;
    cache_reqTagIn = 28'h000002A;
    cache_reqTagValidIn = 1'b1;
    push_rd(30'hA8, t0 + 1, 4);
    push_rsp(28'h000002A, 128'h000000AB_000000AA_000000A9_000000A8, t0 + 6);
    wait_cycles(7);
    cache_reqTagValidIn = 1'b0;
    @(negedge Clock);
    chk("post_rst_fetch", 128'(debug_fetchCount), 128'd1);
    chk("post_rst_drop", 128'(debug_dropCount), 128'd0);

    // Request held high: refetch every 7 cycles
    wait_cycles(1);
    t0 = cyc;
    cache_reqTagIn = 28'h0000003;
    cache_reqTagValidIn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_rd(30'hC, t0 + 1 + 7 * i, 4);
      push_rsp(28'h0000003, 128'h0000000F_0000000E_0000000D_0000000C, t0 + 6 + 7 * i);
    end
    for (int i = 0; i < 3; i++) begin
      wait_cycles(7);
      if (i == 2) cache_reqTagValidIn = 1'b0;
      @(negedge Clock);
      chk("held_fetch", 128'(debug_fetchCount), 128'(2 + i));
    end
    @(negedge Clock);
    chk("held_idle_state", 128'(debug_state), 128'd0);

    wait_cycles(4);
    chk("rd_left", 128'(rd_q.size()), 128'd0);
    chk("rsp_left", 128'(rsp_q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifu_mem_rsp.md
# ifu_mem_rsp

Memory-side responder for the instruction-fetch unit's line-refill protocol. It accepts a tag request from the instruction cache, reads the line from a word-wide synchronous instruction memory one word per cycle, assembles the full line, and returns it with its tag as a single-cycle response. It sits between the IFU cache's memory interface and the backing instruction RAM.

## Interface

Parameters, all sourced from `ifu_pkg`:

- `TAG_WIDTH`, 28: width of the line tag.
- `LINE_WIDTH`, 128: width of a cache line.
- `WORD_WIDTH`, 32: width of a memory read word.
- `MEM_ADDR_WIDTH`, 30: word address width of the instruction memory.
- `WORDS_PER_LINE`, `LINE_WIDTH/WORD_WIDTH` (4): number of reads per line.
- `BEAT_WIDTH`, `$clog2(WORDS_PER_LINE)` (2): width of the beat index.

Ports:

- `Clock` in 1: single clock; all logic is on the rising edge.
- `Rst` in 1: synchronous, active-high reset.
- `cache_reqTagIn` in `TAG_WIDTH`: requested line tag.
- `cache_reqTagValidIn` in 1: level request; the cache holds it high while missing.
- `cache_rspTagOut` out `TAG_WIDTH`: tag of the returned line.
- `cache_rspInsLineOut` out `LINE_WIDTH`: the returned line.
- `cache_rspInsLineValidOut` out 1: response valid, one-cycle pulse.
- `imem_rdEnOut` out 1: memory read enable.
- `imem_rdAddrOut` out `MEM_ADDR_WIDTH`: memory word address.
- `imem_rdDataIn` in `WORD_WIDTH`: read data, valid the cycle after `imem_rdEnOut`.
- `busyOut` out 1: high whenever the state is not `S_IDLE`.
- `debug_state` out 2: current FSM state encoding.
- `debug_fetchCount` out 16: number of lines delivered; wraps from 0xFFFF to 0.
- `debug_dropCount` out 16: number of fetches discarded as stale; wraps from 0xFFFF to 0.

## Operation

- **Base address.** Base word address = `{reqTag, BEAT_WIDTH'b0}`, zero-extended or truncated to `MEM_ADDR_WIDTH`. The address for beat k is base + k, with no carry into other lines.
- **Line packing.** Word k is placed at `line[k*WORD_WIDTH +: WORD_WIDTH]`, so word 0 occupies the LSBs.
- **FSM** (`rsp_state_t`):
  - `S_IDLE`: if `cache_reqTagValidIn` is high, latch the tag, clear `stale` and the beat counter, and go to `S_FETCH`.
  - `S_FETCH`: assert `imem_rdEnOut` with the address for the current beat, then increment the beat. After issuing beat `WORDS_PER_LINE-1`, go to `S_DRAIN`.
  - `S_DRAIN`: capture the last word and go to `S_RESP`.
  - `S_RESP`: assert `cache_rspInsLineValidOut` with the registered tag and line, increment `debug_fetchCount`, and go to `S_IDLE`. If `stale` is set, keep the valid low, increment `debug_dropCount` instead, and go to `S_IDLE`.
- **Capture.** Read data is captured into the line buffer using a one-cycle delayed copy of the read-enable and beat index. This capture happens in both `S_FETCH` and `S_DRAIN`.
- **Stale detection.** In `S_FETCH` or `S_DRAIN`, if `cache_reqTagValidIn` is low or `cache_reqTagIn` differs from the latched tag, set `stale`.
  - `stale` is sticky until the next `S_IDLE` acceptance.
  - A stale fetch still completes all reads and is never aborted.
- **No queueing.** Requests are sampled only in `S_IDLE`. A request that is still held after `S_RESP` is serviced again if it is still valid in `S_IDLE`.
- **Output registers.** `cache_rspTagOut` and `cache_rspInsLineOut` are registered. They hold their last value when valid is low.

## Timing

- **Reset.**
  - State returns to `S_IDLE`.
  - All outputs are 0: valid, read enable, address, tag, line, counters, `busyOut`, `debug_state` = 0 (`S_IDLE`).
  - The line buffer, `stale`, and the beat counter are cleared.
  - Reset mid-fetch drops any in-flight read data. It is not captured.
- **Latency.** With the request first valid in `S_IDLE` at cycle t:
  - `imem_rdEnOut` is high during cycles t+1 through t+N (N = `WORDS_PER_LINE`).
  - Data returns in cycles t+2 through t+N+1.
  - `cache_rspInsLineValidOut` is high in cycle t+N+2 only.
  - For N = 4 the response is at t+6, and a complete turnaround is N+3 = 7 cycles.
- **Read-enable pattern.** Exactly N back-to-back read enables per accepted request. Never more than one request is in flight.
- **Cache timing.** The cache writes the line on the `S_RESP` edge. Its request drops in the following `S_IDLE` cycle because it now hits, so no duplicate fetch occurs.

## Structure

- **`ifu_pkg` additions:** `WORD_WIDTH`, `MEM_ADDR_WIDTH`, `WORDS_PER_LINE`, `BEAT_WIDTH`, and `typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_RESP} rsp_state_t`.
- **Module:** a single module with no sub-module. The line buffer, beat counter, delayed capture registers, and counters are all local.

## Test plan

1. **Single miss.** Memory word at address A holds A. Request tag 0x0000005 at t.
   - Read addresses are 0x14, 0x15, 0x16, 0x17 during t+1 through t+4.
   - At t+6, valid=1, tag=0x0000005, line=0x00000017_00000016_00000015_00000014.
   - `debug_fetchCount`=1.
2. **Stale fetch.** Same request, but the valid is dropped at t+2.
   - Four reads are still issued.
   - No valid pulse is produced.
   - `debug_dropCount`=1; the state is `S_IDLE` at t+7.
3. **Tag change.** The tag switches from 0x5 to 0x9 during `S_FETCH`.
   - The 0x5 fetch is dropped.
   - The 0x9 request is accepted in the next `S_IDLE` and delivered 6 cycles later.
4. **Address edge.** Tag 0xFFFFFFF.
   - Addresses are 0x3FFFFFFC through 0x3FFFFFFF.
   - The line packs those four words correctly.
5. **Reset mid-fetch.** `Rst` is asserted at t+3 for one cycle.
   - All outputs are 0 the next cycle, with `busyOut`=0.
   - No response is generated.
   - A fresh request afterwards is served normally.
6. **Request held high.** Same tag held continuously.
   - A refetch occurs every 7 cycles.
   - The valid pulse is exactly one cycle wide.
   - `debug_fetchCount` increments once per response.
